// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial add sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_STEP_CYCLES = 12000000;

  // Carry-out of a one-bit full adder.
  function automatic logic majority3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step timer: counts 0..STEP_CYCLES-1 while enabled and flags the terminal
// count with a one-cycle tick. A synchronous clear restarts it from 0.
module step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(STEP_CYCLES + 1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TC);

  // Next count: clear wins, then wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == TC) cnt_d = '0;
      else             cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Serial add sequencer: captures two operands and feeds them LSB-first, one
// bit pair plus running carry per step, to a one-bit full-adder stage. Each
// step is held for STEP_CYCLES clocks. The sum is assembled locally.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input for two's-complement
// A-B (B inverted at capture, carry seeded with 1).
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SHIFT | presenting bit idx, timer running
// DONE  | sum/cout valid and held until next start
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                     sub,
`endif
  input  logic                     start,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  output logic                     bit_a,
  output logic                     bit_b,
  output logic                     bit_cin,
  output logic                     bit_valid,
  output logic [$clog2(WIDTH):0]   bit_idx,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout
);

  localparam int IDX_W = $clog2(WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               tick;
  logic               accept;
  logic [WIDTH-1:0]   b_cap;
  logic               carry_init;
  logic               s_bit;
  logic               c_new;

`ifdef SERIAL_ADD_SUB_EN
  assign b_cap      = sub ? ~op_b : op_b;
  assign carry_init = sub;
`else
  assign b_cap      = op_b;
  assign carry_init = 1'b0;
`endif

  // Start is honoured in IDLE and DONE only; a start during SHIFT is dropped.
  assign accept = start && (state_q != SHIFT);

  // The operand registers shift right each step, so bit 0 is always live.
  assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_new = majority3(a_q[0], b_q[0], carry_q);

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state_q == SHIFT),
    .tick  (tick)
  );

  // Next-state, operand shift and sum assembly.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = b_cap;
          carry_d = carry_init;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sum_d   = sum_q | (WIDTH'(s_bit) << idx_q);
          carry_d = c_new;
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          if (idx_q == LAST_IDX) begin
            cout_d  = c_new;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign bit_valid = busy;
  assign done      = (state_q == DONE);
  assign bit_a     = busy & a_q[0];
  assign bit_b     = busy & b_q[0];
  assign bit_cin   = busy & carry_q;
  assign bit_idx   = idx_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: WIDTH=4/STEP_CYCLES=4 main instance plus a
// WIDTH=1/STEP_CYCLES=1 instance.
module tb_serial_add_sequencer;

  localparam int W = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         sub_i = 1'b0;
  logic         bit_a, bit_b, bit_cin, bit_valid, busy, done, cout;
  logic [2:0]   bit_idx;
  logic [W-1:0] sum;

  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic bit_a1, bit_b1, bit_cin1, bit_valid1, busy1, done1, cout1;
  logic [0:0] bit_idx1, sum1;

  serial_add_sequencer #(.WIDTH(W), .STEP_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_i),
`endif
    .start(start), .op_a(op_a), .op_b(op_b),
    .bit_a(bit_a), .bit_b(bit_b), .bit_cin(bit_cin), .bit_valid(bit_valid),
    .bit_idx(bit_idx), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_sequencer #(.WIDTH(1), .STEP_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADD_SUB_EN
    .sub(1'b0),
`endif
    .start(start1), .op_a(a1), .op_b(b1),
    .bit_a(bit_a1), .bit_b(bit_b1), .bit_cin(bit_cin1), .bit_valid(bit_valid1),
    .bit_idx(bit_idx1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  res_t sb[$];
  vec_t vecs[7];

  // One full run on the main instance; poke=1 fires a stray start with
  // different operands in the middle of the run.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sb_sub, input logic [W-1:0] exp_sum,
                         input logic exp_cout, input bit poke);
    logic [W-1:0] be;
    logic c;
    int k;
    int waited;
    res_t r;
    @(posedge clk); #1;
    op_a = a; op_b = b; sub_i = sb_sub; start = 1'b1;
    be = sub_i ? ~b : b;
    c  = sub_i;
    sb.push_back('{exp_sum, exp_cout});
    @(posedge clk); #1;
    start = 1'b0;
    check("done_drop", done, 0);
    check("sum_clear", sum, 0);
    for (int n = 0; n < W*S; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (poke && n == 5) begin start = 1'b1; op_a = ~a; op_b = ~b; end
      else if (poke && n == 6) start = 1'b0;
      k = n / S;
      check("bit_valid", bit_valid, 1);
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("bit_idx", bit_idx, k);
      check("bit_a", bit_a, a[k]);
      check("bit_b", bit_b, be[k]);
      check("bit_cin", bit_cin, c);
      if (n % S == S-1) c = (a[k] & be[k]) | (a[k] & c) | (be[k] & c);
    end
    waited = 0;
    @(posedge clk); #1;
    while (!done && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    check("done_latency", waited, 0);
    check("busy_end", busy, 0);
    check("valid_end", bit_valid, 0);
    check("bits_end", {bit_a, bit_b, bit_cin}, 0);
    check("cout_model", cout, c);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      r = sb.pop_front();
      check("sum", sum, r.sum);
      check("cout", cout, r.cout);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0};
    vecs[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
    vecs[2] = '{4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0};
    vecs[3] = '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1};
    vecs[4] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[5] = '{4'b1001, 4'b0111, 1'b0, 4'b0000, 1'b1};
    vecs[6] = '{4'b0110, 4'b0010, 1'b1, 4'b0100, 1'b1};
`ifdef SERIAL_ADD_SUB_EN
    nv = 7;
`else
    nv = 6;
`endif

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bit_valid, 0);
    check("rst_bits", {bit_a, bit_b, bit_cin}, 0);
    check("rst_idx", bit_idx, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++)
      run_add(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout, 1'b0);

    // Stray start mid-run is ignored, then a start from DONE restarts.
    run_add(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);
    run_add(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Reset in the middle of step 2 discards the run.
    @(posedge clk); #1;
    op_a = 4'b1011; op_b = 4'b0110; sub_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2*S + 1) @(posedge clk);
    #1;
    check("pre_rst_idx", bit_idx, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bit_valid, 0);
    check("mid_rst_bits", {bit_a, bit_b, bit_cin}, 0);
    check("mid_rst_idx", bit_idx, 0);
    @(posedge clk); #1;
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    rst_n = 1'b1;
    run_add(4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0);

    // Single-bit, single-cycle instance.
    @(posedge clk); #1;
    a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("w1_valid", bit_valid1, 1);
    check("w1_bits", {bit_a1, bit_b1, bit_cin1}, 3'b110);
    check("w1_done_early", done1, 0);
    @(posedge clk); #1;
    check("w1_valid_end", bit_valid1, 0);
    check("w1_done", done1, 1);
    check("w1_sum", sum1, 0);
    check("w1_cout", cout1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
